// File: rtl/vga_sync_gen.sv
// Free-running VGA raster timing generator: wrapping pixel/line counters with
// registered HSYNC/VSYNC and one-cycle line/frame start pulses.
module vga_sync_gen #(
    parameter int H_RES     = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_RES     = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0
) (
    input  logic        PIX_CLK,
    input  logic        RST_N,
    input  logic        EN,
    output logic [11:0] HORIZONTAL,
    output logic [11:0] VERTICAL,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        LINE_START,
    output logic        FRAME_START
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_MAX    = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_MAX    = 12'(V_TOTAL - 1);
    localparam logic [11:0] HS_FIRST = 12'(H_RES + H_FP);
    localparam logic [11:0] HS_LAST  = 12'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_FIRST = 12'(V_RES + V_FP);
    localparam logic [11:0] VS_LAST  = 12'(V_RES + V_FP + V_SYNC - 1);
    localparam logic        HS_ACT   = (HSYNC_POL != 0);
    localparam logic        VS_ACT   = (VSYNC_POL != 0);

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_check
            $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 4096");
        end
    endgenerate

    logic        h_wrap;
    logic        v_wrap;
    logic [11:0] h_next;
    logic [11:0] v_next;
    logic        hs_next;
    logic        vs_next;

    // Syncs are decoded from the next counter values so they register in the
    // same cycle as the position they belong to.
    always_comb begin
        h_wrap = (HORIZONTAL == H_MAX);
        v_wrap = (VERTICAL == V_MAX);
        h_next = h_wrap ? 12'd0 : HORIZONTAL + 12'd1;
        v_next = VERTICAL;
        if (h_wrap) begin
            v_next = v_wrap ? 12'd0 : VERTICAL + 12'd1;
        end
        hs_next = (h_next >= HS_FIRST && h_next <= HS_LAST) ? HS_ACT : ~HS_ACT;
        vs_next = (v_next >= VS_FIRST && v_next <= VS_LAST) ? VS_ACT : ~VS_ACT;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge PIX_CLK or negedge RST_N) begin
        if (!RST_N) begin
            HORIZONTAL  <= 12'd0;
            VERTICAL    <= 12'd0;
            HSYNC       <= ~HS_ACT;
            VSYNC       <= ~VS_ACT;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else if (EN) begin
            HORIZONTAL  <= h_next;
            VERTICAL    <= v_next;
            HSYNC       <= hs_next;
            VSYNC       <= vs_next;
            LINE_START  <= h_wrap;
            FRAME_START <= h_wrap && v_wrap;
        end else begin
            // Pulses drop while stalled and are not replayed on re-enable.
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed testbench for vga_sync_gen: default 1024x768 timing, a 640x480
// override, and a tiny active-high raster small enough to wrap whole frames.
module tb_vga_sync_gen;

    logic clk;
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default 1024x768 instance
    logic        rst_d, en_d;
    logic [11:0] h_d, v_d;
    logic        hs_d, vs_d, ls_d, fs_d;

    vga_sync_gen u_def (
        .PIX_CLK(clk), .RST_N(rst_d), .EN(en_d),
        .HORIZONTAL(h_d), .VERTICAL(v_d), .HSYNC(hs_d), .VSYNC(vs_d),
        .LINE_START(ls_d), .FRAME_START(fs_d)
    );

    // 640x480 override
    logic        rst_v, en_v;
    logic [11:0] h_v, v_v;
    logic        hs_v, vs_v, ls_v, fs_v;

    vga_sync_gen #(
        .H_RES(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_RES(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .HSYNC_POL(0), .VSYNC_POL(0)
    ) u_vga (
        .PIX_CLK(clk), .RST_N(rst_v), .EN(en_v),
        .HORIZONTAL(h_v), .VERTICAL(v_v), .HSYNC(hs_v), .VSYNC(vs_v),
        .LINE_START(ls_v), .FRAME_START(fs_v)
    );

    // Tiny raster: H_TOTAL=16 (sync 10..12), V_TOTAL=9 (sync 5..6), active-high
    logic        rst_t, en_t;
    logic [11:0] h_t, v_t;
    logic        hs_t, vs_t, ls_t, fs_t;

    vga_sync_gen #(
        .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HSYNC_POL(1), .VSYNC_POL(1)
    ) u_tiny (
        .PIX_CLK(clk), .RST_N(rst_t), .EN(en_t),
        .HORIZONTAL(h_t), .VERTICAL(v_t), .HSYNC(hs_t), .VSYNC(vs_t),
        .LINE_START(ls_t), .FRAME_START(fs_t)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int bad;
        int cnt;
        int found;
        int eh;
        int ev;
        logic [11:0] h_at_last;
        logic [11:0] v_at_wrap;
        logic        ls_at_wrap;
        logic        fs_at_frame;
        logic        ls_at_frame;

        rst_d = 1'b0; en_d = 1'b0;
        rst_v = 1'b0; en_v = 1'b0;
        rst_t = 1'b0; en_t = 1'b0;

        // ---- Reset values (default instance) ----
        repeat (5) @(negedge clk);
        check("rst_h", 32'(h_d), 0);
        check("rst_v", 32'(v_d), 0);
        check("rst_hsync", 32'(hs_d), 1);
        check("rst_vsync", 32'(vs_d), 1);
        check("rst_line_start", 32'(ls_d), 0);
        check("rst_frame_start", 32'(fs_d), 0);

        // ---- Line timing: k counts posedges since release ----
        rst_d = 1'b1; en_d = 1'b1;
        bad = 0; cnt = 0;
        h_at_last = '0; v_at_wrap = '0; ls_at_wrap = 1'b0;
        for (int k = 1; k <= 1350; k++) begin
            @(negedge clk);
            eh = k % 1344;
            ev = k / 1344;
            if (h_d !== 12'(eh) || v_d !== 12'(ev) || vs_d !== 1'b1 || fs_d !== 1'b0 ||
                hs_d !== !(eh >= 1048 && eh <= 1183) || ls_d !== (eh == 0))
                bad++;
            if (hs_d === 1'b0 && ev == 0) cnt++;
            if (k == 1)    check("first_edge_h", 32'(h_d), 1);
            if (k == 1343) h_at_last = h_d;
            if (k == 1344) begin
                v_at_wrap  = v_d;
                ls_at_wrap = ls_d;
            end
        end
        check("line_sweep_bad_cycles", bad, 0);
        check("hsync_low_cycles", cnt, 136);
        check("h_last_value", 32'(h_at_last), 1343);
        check("v_after_wrap", 32'(v_at_wrap), 1);
        check("ls_at_wrap", 32'(ls_at_wrap), 1);

        // ---- Enable stall at (0,5) ----
        repeat (6720 - 1350) @(negedge clk);
        check("stall_pre_h", 32'(h_d), 0);
        check("stall_pre_v", 32'(v_d), 5);
        check("stall_pre_ls", 32'(ls_d), 1);
        en_d = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (h_d !== 12'd0 || v_d !== 12'd5 || ls_d !== 1'b0 || hs_d !== 1'b1) bad++;
        end
        check("stall_hold_bad_cycles", bad, 0);
        en_d = 1'b1;
        @(negedge clk);
        check("resume_h", 32'(h_d), 1);
        check("resume_v", 32'(v_d), 5);
        check("resume_ls", 32'(ls_d), 0);

        // ---- Mid-frame asynchronous reset while HSYNC is active ----
        repeat (1099) @(negedge clk);
        check("pre_reset_h", 32'(h_d), 1100);
        check("pre_reset_hsync", 32'(hs_d), 0);
        #2 rst_d = 1'b0;
        #1;
        check("async_rst_h", 32'(h_d), 0);
        check("async_rst_v", 32'(v_d), 0);
        check("async_rst_hsync", 32'(hs_d), 1);
        check("async_rst_ls", 32'(ls_d), 0);
        repeat (2) @(negedge clk);
        rst_d = 1'b1;
        found = -1;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (ls_d === 1'b1) begin
                found = k;
                break;
            end
        end
        check("post_reset_first_ls_cycle", found, 1344);
        check("post_reset_ls_h", 32'(h_d), 0);
        check("post_reset_ls_v", 32'(v_d), 1);
        en_d = 1'b0;

        // ---- 640x480 override: one line plus a few pixels ----
        @(negedge clk);
        check("vga_rst_hsync", 32'(hs_v), 1);
        check("vga_rst_vsync", 32'(vs_v), 1);
        rst_v = 1'b1; en_v = 1'b1;
        bad = 0; cnt = 0;
        h_at_last = '0; v_at_wrap = '0;
        for (int k = 1; k <= 805; k++) begin
            @(negedge clk);
            eh = k % 800;
            ev = k / 800;
            if (h_v !== 12'(eh) || v_v !== 12'(ev) || vs_v !== 1'b1 ||
                hs_v !== !(eh >= 656 && eh <= 751) || ls_v !== (eh == 0))
                bad++;
            if (hs_v === 1'b0 && ev == 0) cnt++;
            if (k == 799) h_at_last = h_v;
            if (k == 800) v_at_wrap = v_v;
        end
        check("vga_sweep_bad_cycles", bad, 0);
        check("vga_hsync_low_cycles", cnt, 96);
        check("vga_h_last_value", 32'(h_at_last), 799);
        check("vga_v_after_wrap", 32'(v_at_wrap), 1);
        en_v = 1'b0;

        // ---- Tiny active-high raster: full frames, VSYNC, FRAME_START ----
        @(negedge clk);
        check("tiny_rst_hsync", 32'(hs_t), 0);
        check("tiny_rst_vsync", 32'(vs_t), 0);
        rst_t = 1'b1; en_t = 1'b1;
        bad = 0; cnt = 0; found = 0;
        fs_at_frame = 1'b0; ls_at_frame = 1'b0;
        for (int k = 1; k <= 2 * 144 + 3; k++) begin
            @(negedge clk);
            eh = k % 16;
            ev = (k / 16) % 9;
            if (h_t !== 12'(eh) || v_t !== 12'(ev) ||
                hs_t !== (eh >= 10 && eh <= 12) || vs_t !== (ev >= 5 && ev <= 6) ||
                ls_t !== (eh == 0) || fs_t !== (eh == 0 && ev == 0))
                bad++;
            if (vs_t === 1'b1 && k <= 144) cnt++;
            if (fs_t === 1'b1) found++;
            if (k == 144) begin
                fs_at_frame = fs_t;
                ls_at_frame = ls_t;
            end
        end
        check("tiny_sweep_bad_cycles", bad, 0);
        check("tiny_vsync_high_cycles", cnt, 32);
        check("tiny_frame_start_count", found, 2);
        check("tiny_fs_at_frame_wrap", 32'(fs_at_frame), 1);
        check("tiny_ls_at_frame_wrap", 32'(ls_at_frame), 1);
        en_t = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
